fc_event_queue: RTL and testbench



---
 rtl/fc_event_queue_pkg.sv | 21 ++
 rtl/fc_event_rr_arbiter.sv | 40 ++++
 rtl/fc_event_queue.sv | 146 ++++++++++++++
 tb/tb_fc_event_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_event_queue_pkg.sv
// ------------------------------------------------------------------------
// fc_event_queue_pkg : shared constants and types for the FC event queue
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

package fc_event_queue_pkg;

   localparam int FC_EVENT_LOST_CNT_W    = 16;
   localparam int FC_EVENT_WIDTH_DEFAULT = 8;

   typedef logic [FC_EVENT_WIDTH_DEFAULT-1:0] fc_event_id_t;

   // Index width for a vector of n entries, never narrower than one bit.
   function automatic int fc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fc_event_rr_arbiter.sv
// ------------------------------------------------------------------------
// fc_event_rr_arbiter : picks the first pending source at or above rr_ptr
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

module fc_event_rr_arbiter
   import fc_event_queue_pkg::*;
#(
   parameter  int NB_SOURCES = 32,
   localparam int IDX_W      = fc_idx_w(NB_SOURCES)
) (
   input  logic [NB_SOURCES-1:0] pend_i,
   input  logic [IDX_W-1:0]      rr_ptr_i,
   output logic                  gnt_valid_o,
   output logic [IDX_W-1:0]      gnt_idx_o
);

   logic [IDX_W:0] cand;

   // Scan from the farthest offset down so the nearest hit overwrites the rest.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      cand        = '0;
      for (int k = NB_SOURCES - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NB_SOURCES)) begin
            cand = cand - (IDX_W+1)'(NB_SOURCES);
         end
         if (pend_i[cand[IDX_W-1:0]]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fc_event_queue.sv
// ------------------------------------------------------------------------
// fc_event_queue : pending flags + round-robin pick + event ID FIFO
// Optional lost-event counter: FC_EVENT_QUEUE_LOST_CNT_EN. Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

module fc_event_queue
   import fc_event_queue_pkg::*;
#(
   parameter int NB_SOURCES  = 32,
   parameter int EVENT_WIDTH = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NB_SOURCES-1:0]          events_i,
   output logic [EVENT_WIDTH-1:0]         event_data_o,
   output logic                           event_valid_o,
   input  logic                           event_ready_i,
   output logic [NB_SOURCES-1:0]          pending_o,
   output logic                           fifo_full_o,
   input  logic                           overflow_clr_i,
   output logic [FC_EVENT_LOST_CNT_W-1:0] lost_cnt_o
);

   localparam int              IDX_W   = fc_idx_w(NB_SOURCES);
   localparam int              AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST_C = IDX_W'(NB_SOURCES - 1);

   logic [NB_SOURCES-1:0]  pend_q, pend_d;
   logic [NB_SOURCES-1:0]  gnt_oh, lost;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       gnt_idx;
   logic                   gnt_valid;
   logic                   push, pop;
   logic [EVENT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [EVENT_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;

   fc_event_rr_arbiter #(
      .NB_SOURCES (NB_SOURCES)
   ) u_arbiter (
      .pend_i      (pend_q),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // No full-bypass: a pop in the same cycle does not free a slot for push.
   always_comb begin
      push   = gnt_valid && (count_q != DEPTH_C);
      pop    = event_valid_o && event_ready_i;
      gnt_oh = '0;
      if (push) begin
         gnt_oh[gnt_idx] = 1'b1;
      end
      lost   = events_i & pend_q & ~gnt_oh;
      pend_d = (pend_q & ~gnt_oh) | events_i;

      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (gnt_idx == LAST_C) ? '0 : gnt_idx + IDX_W'(1);
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = EVENT_WIDTH'(gnt_idx);
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q   <= '0;
         rr_ptr_q <= '0;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pend_q   <= pend_d;
         rr_ptr_q <= rr_ptr_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign event_valid_o = (count_q != '0);
   assign fifo_full_o   = (count_q == DEPTH_C);
   assign event_data_o  = mem_q[rd_ptr_q];
   assign pending_o     = pend_q;

`ifdef FC_EVENT_QUEUE_LOST_CNT_EN
   logic [FC_EVENT_LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;
   logic [FC_EVENT_LOST_CNT_W:0]   lost_sum;

   // One spare bit in the sum detects saturation; clear beats increment.
   always_comb begin
      lost_sum = {1'b0, lost_cnt_q};
      for (int i = 0; i < NB_SOURCES; i++) begin
         lost_sum = lost_sum + (FC_EVENT_LOST_CNT_W+1)'(lost[i]);
      end
      if (overflow_clr_i) begin
         lost_cnt_d = '0;
      end else if (lost_sum[FC_EVENT_LOST_CNT_W]) begin
         lost_cnt_d = '1;
      end else begin
         lost_cnt_d = lost_sum[FC_EVENT_LOST_CNT_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lost_cnt_q <= '0;
      end else begin
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign lost_cnt_o = lost_cnt_q;
`else
   logic unused_lost;
   assign unused_lost = ^{overflow_clr_i, lost};
   assign lost_cnt_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fc_event_queue.sv
// ------------------------------------------------------------------------
// tb_fc_event_queue : scoreboard bench for fc_event_queue (directed + random)
// Revision 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_fc_event_queue;

   localparam int NB    = 32;
   localparam int EW    = 8;
   localparam int DEPTH = 4;
`ifdef FC_EVENT_QUEUE_LOST_CNT_EN
   localparam int LOST_EN = 1;
`else
   localparam int LOST_EN = 0;
`endif

   logic          clk            = 1'b0;
   logic          rst_ni         = 1'b0;
   logic [NB-1:0] events_i       = '0;
   logic          event_ready_i  = 1'b0;
   logic          overflow_clr_i = 1'b0;
   logic [EW-1:0] event_data_o;
   logic          event_valid_o;
   logic [NB-1:0] pending_o;
   logic          fifo_full_o;
   logic [15:0]   lost_cnt_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fc_event_queue #(
      .NB_SOURCES  (NB),
      .EVENT_WIDTH (EW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .events_i       (events_i),
      .event_data_o   (event_data_o),
      .event_valid_o  (event_valid_o),
      .event_ready_i  (event_ready_i),
      .pending_o      (pending_o),
      .fifo_full_o    (fifo_full_o),
      .overflow_clr_i (overflow_clr_i),
      .lost_cnt_o     (lost_cnt_o)
   );

   // Reference model state: pending set, pointer, occupancy, expected IDs.
   logic [NB-1:0] m_pend = '0;
   int            m_rr   = 0;
   int            m_occ  = 0;
   int            m_lost = 0;
   int            exp_q[$];
   int            popped[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pop_at(input int i);
      return (i < popped.size()) ? popped[i] : -1;
   endfunction

   initial forever begin : model
      int g;
      int nlost;
      bit do_pop;
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
         m_pend = '0;
         m_rr   = 0;
         m_occ  = 0;
         m_lost = 0;
         exp_q.delete();
      end else begin
         do_pop = (m_occ > 0) && event_ready_i;
         g = -1;
         if (m_occ < DEPTH) begin
            for (int k = 0; k < NB; k++) begin
               if (g < 0 && m_pend[(m_rr + k) % NB]) g = (m_rr + k) % NB;
            end
         end
         nlost = 0;
         for (int i = 0; i < NB; i++) begin
            if (events_i[i] && m_pend[i] && i != g) nlost++;
         end
         if (g >= 0) begin
            m_pend[g] = 1'b0;
            m_rr      = (g + 1) % NB;
            exp_q.push_back(g);
            m_occ++;
         end
         m_pend = m_pend | events_i;
         if (do_pop) m_occ--;
         if (LOST_EN != 0) begin
            if (overflow_clr_i) m_lost = 0;
            else m_lost = (m_lost + nlost > 65535) ? 65535 : m_lost + nlost;
         end
      end
   end

   initial forever begin : monitor
      @(negedge clk);
      chk("valid", event_valid_o, 64'(m_occ > 0));
      chk("full", fifo_full_o, 64'(m_occ == DEPTH));
      chk("pending", pending_o, m_pend);
      chk("lost_cnt", lost_cnt_o, 64'(m_lost));
      chk("sb_depth", 64'(exp_q.size()), 64'(m_occ));
      if (event_valid_o) begin
         if (exp_q.size() > 0) chk("head_data", event_data_o, 64'(exp_q[0]));
         if (event_ready_i) begin
            popped.push_back(int'(event_data_o));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step(input logic [NB-1:0] ev, input logic rdy, input logic clr);
      events_i       = ev;
      event_ready_i  = rdy;
      overflow_clr_i = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      events_i       = '0;
      event_ready_i  = 1'b0;
      overflow_clr_i = 1'b0;
      rst_ni         = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_ni = 1'b1;
      popped.delete();
   endtask

   task automatic drain(input string name, input int want);
      for (int n = 0; n < 60 && popped.size() < want; n++) step('0, 1'b1, 1'b0);
      chk(name, 64'(popped.size()), 64'(want));
   endtask

   initial begin : stimulus
      int pct;
      do_reset();
      chk("rst_valid", event_valid_o, 0);
      chk("rst_full", fifo_full_o, 0);
      chk("rst_data", event_data_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_lost", lost_cnt_o, 0);

      // single event: valid two cycles after the pulse
      step(32'h0000_0020, 1'b0, 1'b0);
      chk("single_not_yet", event_valid_o, 0);
      step('0, 1'b0, 1'b0);
      chk("single_valid", event_valid_o, 1);
      chk("single_data", event_data_o, 8'h05);
      step('0, 1'b1, 1'b0);
      chk("single_popped", event_valid_o, 0);

      // round-robin order
      do_reset();
      step(32'h8000_0408, 1'b0, 1'b0);
      drain("rr_a_count", 3);
      chk("rr_a0", 64'(pop_at(0)), 3);
      chk("rr_a1", 64'(pop_at(1)), 10);
      chk("rr_a2", 64'(pop_at(2)), 31);
      popped.delete();
      step(32'h8000_0004, 1'b0, 1'b0);
      drain("rr_b_count", 2);
      chk("rr_b0", 64'(pop_at(0)), 2);
      chk("rr_b1", 64'(pop_at(1)), 31);

      // full FIFO, then back-to-back drain
      do_reset();
      step(32'h0000_003F, 1'b0, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0);
      chk("full_c4", fifo_full_o, 0);
      step('0, 1'b0, 1'b0);
      chk("full_c5", fifo_full_o, 1);
      chk("full_pending", pending_o, 32'h30);
      repeat (6) step('0, 1'b1, 1'b0);
      chk("full_nogap", 64'(popped.size()), 6);
      for (int i = 0; i < 6; i++) chk("full_order", 64'(pop_at(i)), 64'(i));
      chk("full_empty", event_valid_o, 0);

      // same-cycle grant and pulse on source 7
      do_reset();
      step(32'h80, 1'b0, 1'b0);
      step(32'h80, 1'b0, 1'b0);
      drain("same_count", 2);
      chk("same_0", 64'(pop_at(0)), 7);
      chk("same_1", 64'(pop_at(1)), 7);
      chk("same_lost", lost_cnt_o, 0);

      // lost events on source 9 while full
      do_reset();
      step(32'h0F, 1'b0, 1'b0);
      repeat (4) step('0, 1'b0, 1'b0);
      step(32'h200, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      step(32'h200, 1'b0, 1'b0);
      step(32'h200, 1'b0, 1'b0);
      chk("lost_two", lost_cnt_o, 64'(LOST_EN * 2));
      step(32'h200, 1'b0, 1'b1);
      chk("lost_clear", lost_cnt_o, 0);

      // asynchronous reset mid-operation
      do_reset();
      step(32'h1F, 1'b0, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0);
      chk("mid_pending", pending_o, 32'h18);
      rst_ni = 1'b0;
      #1;
      chk("mid_valid", event_valid_o, 0);
      chk("mid_full", fifo_full_o, 0);
      chk("mid_data", event_data_o, 0);
      chk("mid_pend0", pending_o, 0);
      chk("mid_lost", lost_cnt_o, 0);
      @(posedge clk);
      #2;
      rst_ni = 1'b1;
      step(32'h2, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      chk("post_valid", event_valid_o, 1);
      chk("post_data", event_data_o, 8'h01);

      // randomized traffic in segments with different ready duty cycles
      do_reset();
      for (int seg = 0; seg < 6; seg++) begin
         pct = (seg % 3 == 0) ? 90 : (seg % 3 == 1) ? 20 : 60;
         for (int c = 0; c < 250; c++) begin
            if (seg < 3) step($urandom & $urandom & $urandom & $urandom,
                              1'($urandom_range(0, 99) < pct), 1'($urandom_range(0, 63) == 0));
            else         step($urandom & $urandom,
                              1'($urandom_range(0, 99) < pct), 1'($urandom_range(0, 15) == 0));
         end
      end
      for (int n = 0; n < 200 && (exp_q.size() != 0 || m_pend != '0); n++) step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("final_valid", event_valid_o, 0);
      chk("final_pending", pending_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
